// File: rtl/ram_port_ctrl_pkg.sv
// ============================================================================
// Module      : ram_port_ctrl_pkg
// Description : Shared types and constants for the RAM port controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ram_port_ctrl_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int RSP_DEPTH = 4;
  localparam int RSP_CW    = $clog2(RSP_DEPTH + 1);

endpackage

`default_nettype wire

// File: rtl/ram_port_ctrl_if.sv
// ============================================================================
// Module      : ram_port_ctrl_if / ram_if
// Description : Request/response bus and single-port RAM bus with modports.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface ram_port_ctrl_if #(
  parameter int AWID = 8,
  parameter int DWID = 16
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [AWID-1:0] req_addr;
  logic [DWID-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DWID-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

interface ram_if #(
  parameter int AWID = 8,
  parameter int DWID = 16
);
  logic            we;
  logic [AWID-1:0] addr;
  logic [DWID-1:0] din;
  logic [DWID-1:0] dout;

  modport ctrl (output we, addr, din, input dout);
  modport mem  (input we, addr, din, output dout);
endinterface

`default_nettype wire

// File: rtl/ram_port_rsp_fifo.sv
// ============================================================================
// Module      : ram_port_rsp_fifo
// Description : Small in-order read-response FIFO; head reads as 0 when empty.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ram_port_rsp_fifo #(
  parameter int DWID      = 16,
  parameter int RSP_DEPTH = 4
) (
  input  wire logic                             clk,
  input  wire logic                             rst,
  input  wire logic                             push,
  input  wire logic [DWID-1:0]                  din,
  input  wire logic                             pop,
  output logic      [DWID-1:0]                  dout,
  output logic                                  valid,
  output logic      [$clog2(RSP_DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [PW-1:0] c_last_ptr = PW'(RSP_DEPTH - 1);

  logic [DWID-1:0] r_mem [RSP_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (push) r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + PW'(1);
      if (pop)  r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once pushed.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr] <= din;
  end

  assign valid = (r_count != '0);
  assign dout  = valid ? r_mem[r_rd_ptr] : '0;
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ram_port_ctrl.sv
// ============================================================================
// Module      : ram_port_ctrl
// Description : Valid/ready front end for a 1-cycle-latency RAM with zero-fill.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ram_port_ctrl
  import ram_port_ctrl_pkg::*;
#(
  parameter int DEPTH         = 256,
  parameter int AWID          = 8,
  parameter int DWID          = 16,
  parameter int INIT_ON_RESET = 1
) (
  input  wire logic       clk,
  input  wire logic       rst,
  ram_port_ctrl_if.slave  bus,
  ram_if.ctrl             ram,
  output logic            init_busy
);

  localparam logic [AWID-1:0] c_last_addr   = AWID'(DEPTH - 1);
  localparam state_t          c_reset_state = (INIT_ON_RESET != 0) ? INIT : RUN;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AWID-1:0]   r_init_cnt;
  logic              r_run_en;
  logic [1:0]        r_rd_trk;
  logic              r_ram_we;
  logic [AWID-1:0]   r_ram_addr;
  logic [DWID-1:0]   r_ram_din;

  logic              w_accept;
  logic              w_rd_accept;
  logic              w_req_ready;
  logic              w_init_busy;
  logic              w_pop;
  logic [RSP_CW-1:0] w_inflight;
  logic [RSP_CW-1:0] w_fifo_count;
  logic              w_fifo_valid;
  logic [DWID-1:0]   w_fifo_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_reset_state;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == INIT) && (r_init_cnt == c_last_addr)) w_state_nxt = RUN;
  end

  // Reads in the tracking pipe reserve a FIFO slot so no response is dropped.
  always_comb begin
    w_init_busy = (r_state == INIT);
    w_inflight  = RSP_CW'(r_rd_trk[0]) + RSP_CW'(r_rd_trk[1]);
    w_req_ready = (r_state == RUN) && r_run_en &&
                  ((w_fifo_count + w_inflight) < RSP_CW'(RSP_DEPTH));
    w_accept    = bus.req_valid && w_req_ready;
    w_rd_accept = w_accept && !bus.req_we;
    w_pop       = w_fifo_valid && bus.rsp_ready;
  end

  // r_run_en keeps req_ready low while reset is held when starting in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_init_cnt <= '0;
      r_run_en   <= 1'b0;
      r_rd_trk   <= '0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else begin
      r_run_en <= 1'b1;
      r_rd_trk <= {r_rd_trk[0], w_rd_accept};
      if (r_state == INIT) begin
        r_init_cnt <= r_init_cnt + AWID'(1);
        r_ram_we   <= 1'b1;
        r_ram_addr <= r_init_cnt;
        r_ram_din  <= '0;
      end else if (w_accept) begin
        r_ram_we   <= bus.req_we;
        r_ram_addr <= bus.req_addr;
        if (bus.req_we) r_ram_din <= bus.req_wdata;
      end else begin
        r_ram_we   <= 1'b0;
      end
    end
  end

  ram_port_rsp_fifo #(
    .DWID      (DWID),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_rd_trk[1]),
    .din   (ram.dout),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .valid (w_fifo_valid),
    .count (w_fifo_count)
  );

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_fifo_valid;
  assign bus.rsp_rdata = w_fifo_dout;
  assign ram.we        = r_ram_we;
  assign ram.addr      = r_ram_addr;
  assign ram.din       = r_ram_din;
  assign init_busy     = w_init_busy;

endmodule

`default_nettype wire
